// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
package imem_pkg;

    typedef enum logic {
        IMEM_INIT,
        IMEM_READY
    } imem_state_e;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    typedef struct packed {
        logic misalign;
        logic range;
    } imem_fault_t;

    function automatic logic fault_any(input imem_fault_t f);
        return f.misalign | f.range;
    endfunction

endpackage

// File: rtl/imem_addr_decode.sv
// Combinational byte-address decode: word index, misalignment and range faults.
module imem_addr_decode
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       IDX_W     = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              misalign,
    output logic              range
);

    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * DEPTH);

    logic [ADDR_W-1:0] w_off;

    // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
    assign w_off    = addr - BASE_ADDR;
    assign idx      = w_off[IDX_W+1:2];
    assign misalign = |addr[1:0];
    assign range    = (w_off >= SPAN);

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory: 1-cycle fetch port, program-load port, NOP sweep after reset.
// state      | meaning
// IMEM_INIT  | sweeping INIT_WORD into every word; fetch/load ignored
// IMEM_READY | fetches and loads accepted
module instr_mem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       INIT_WORD = RV_NOP
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fault_misalign,
    output logic              fault_range,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic              ld_err,
    output logic              init_done
);

    localparam int unsigned      IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    imem_state_e       r_state;
    imem_state_e       w_state_nxt;
    logic [IDX_W-1:0]  r_sweep_idx;
    logic [31:0]       r_mem [DEPTH];

    logic [IDX_W-1:0]  w_fetch_idx;
    logic [IDX_W-1:0]  w_ld_idx;
    imem_fault_t       w_fetch_fault;
    imem_fault_t       w_ld_fault;
    logic              w_fetch_acc;
    logic              w_ld_acc;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_widx;
    logic [31:0]       w_mem_wdata;

    logic              r_fetch_valid;
    logic [31:0]       r_fetch_instr;
    imem_fault_t       r_fault;
    logic              r_ld_err;
    logic              r_init_done;

    imem_addr_decode #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_fetch_dec (
        .addr     (fetch_addr),
        .idx      (w_fetch_idx),
        .misalign (w_fetch_fault.misalign),
        .range    (w_fetch_fault.range)
    );

    imem_addr_decode #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_ld_dec (
        .addr     (ld_addr),
        .idx      (w_ld_idx),
        .misalign (w_ld_fault.misalign),
        .range    (w_ld_fault.range)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IMEM_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IMEM_INIT && r_sweep_idx == LAST_IDX) begin
            w_state_nxt = IMEM_READY;
        end
    end

    always_comb begin
        fetch_ready = (r_state == IMEM_READY);
        ld_ready    = (r_state == IMEM_READY);
    end

    assign w_fetch_acc = fetch_req & fetch_ready;
    assign w_ld_acc    = ld_we & ld_ready;

    // Single write port shared by the reset sweep and the load port.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_widx  = r_sweep_idx;
        w_mem_wdata = INIT_WORD;
        if (resetn) begin
            if (r_state == IMEM_INIT) begin
                w_mem_we = 1'b1;
            end else if (w_ld_acc && !fault_any(w_ld_fault)) begin
                w_mem_we    = 1'b1;
                w_mem_widx  = w_ld_idx;
                w_mem_wdata = ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_widx] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sweep_idx   <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= '0;
            r_fault       <= '0;
            r_ld_err      <= 1'b0;
            r_init_done   <= 1'b0;
        end else begin
            if (r_state == IMEM_INIT) begin
                r_sweep_idx <= r_sweep_idx + 1'b1;
                if (r_sweep_idx == LAST_IDX) begin
                    r_init_done <= 1'b1;
                end
            end
            r_fetch_valid <= w_fetch_acc;
            // Read sees the pre-edge array, so a same-cycle load is not visible yet.
            if (w_fetch_acc) begin
                r_fault       <= w_fetch_fault;
                r_fetch_instr <= fault_any(w_fetch_fault) ? 32'h0 : r_mem[w_fetch_idx];
            end
            r_ld_err <= w_ld_acc & fault_any(w_ld_fault);
        end
    end

    assign fetch_valid    = r_fetch_valid;
    assign fetch_instr    = r_fetch_instr;
    assign fault_misalign = r_fault.misalign;
    assign fault_range    = r_fault.range;
    assign ld_err         = r_ld_err;
    assign init_done      = r_init_done;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: vector table plus scoreboard of fetch results.
module tb_instr_mem_ctrl;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DEPTH  = 16;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              a_fetch_req, a_fetch_ready, a_fetch_valid, a_fault_misalign, a_fault_range;
    logic [ADDR_W-1:0] a_fetch_addr, a_ld_addr;
    logic [31:0]       a_fetch_instr, a_ld_data;
    logic              a_ld_we, a_ld_ready, a_ld_err, a_init_done;
    logic              b_fetch_req, b_fetch_ready, b_fetch_valid, b_fault_misalign, b_fault_range;
    logic [ADDR_W-1:0] b_fetch_addr, b_ld_addr;
    logic [31:0]       b_fetch_instr, b_ld_data;
    logic              b_ld_we, b_ld_ready, b_ld_err, b_init_done;

    instr_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(64'h0), .INIT_WORD(NOP)) dut_a (
        .clk(clk), .resetn(resetn),
        .fetch_req(a_fetch_req), .fetch_addr(a_fetch_addr), .fetch_ready(a_fetch_ready),
        .fetch_valid(a_fetch_valid), .fetch_instr(a_fetch_instr),
        .fault_misalign(a_fault_misalign), .fault_range(a_fault_range),
        .ld_we(a_ld_we), .ld_addr(a_ld_addr), .ld_data(a_ld_data), .ld_ready(a_ld_ready),
        .ld_err(a_ld_err), .init_done(a_init_done)
    );

    instr_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(64'h1000), .INIT_WORD(NOP)) dut_b (
        .clk(clk), .resetn(resetn),
        .fetch_req(b_fetch_req), .fetch_addr(b_fetch_addr), .fetch_ready(b_fetch_ready),
        .fetch_valid(b_fetch_valid), .fetch_instr(b_fetch_instr),
        .fault_misalign(b_fault_misalign), .fault_range(b_fault_range),
        .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .ld_ready(b_ld_ready),
        .ld_err(b_ld_err), .init_done(b_init_done)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic        mis;
        logic        rng;
    } exp_t;

    typedef struct {
        logic              is_ld;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        exp_t              exp;
        logic              exp_ld_err;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] model [DEPTH];
    vec_t        vecs [14];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        if (a_fetch_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", {63'b0, a_fetch_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("fetch_result", {30'b0, a_fetch_instr, a_fault_misalign, a_fault_range},
                      {30'b0, e.instr, e.mis, e.rng});
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        sb_check();
    endtask

    function automatic exp_t good(input logic [31:0] d);
        return '{instr: d, mis: 1'b0, rng: 1'b0};
    endfunction

    task automatic fetch(input logic [ADDR_W-1:0] addr, input exp_t e);
        a_fetch_req  = 1'b1;
        a_fetch_addr = addr;
        sb_q.push_back(e);
        cycle();
        a_fetch_req = 1'b0;
        check("fetch_latency", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic load(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic exp_err);
        a_ld_we   = 1'b1;
        a_ld_addr = addr;
        a_ld_data = data;
        cycle();
        a_ld_we = 1'b0;
        check("ld_err", {63'b0, a_ld_err}, {63'b0, exp_err});
        if (!exp_err) model[addr[5:2]] = data;
    endtask

    // Holds requests high throughout the sweep; any acceptance shows up as a stray valid.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        a_fetch_req  = 1'b1;
        a_fetch_addr = 64'h8;
        a_ld_we      = 1'b1;
        a_ld_addr    = 64'h8;
        a_ld_data    = 32'hBAD0BAD0;
        check({name, "_ready_at_release"}, {63'b0, a_fetch_ready}, 64'd0);
        while (!a_fetch_ready && n < 40) begin
            cycle();
            n++;
            if (n == 15) check({name, "_init_done_early"}, {63'b0, a_init_done}, 64'd0);
        end
        a_fetch_req = 1'b0;
        a_ld_we     = 1'b0;
        check({name, "_sweep_cycles"}, 64'(n), 64'd16);
        check({name, "_init_done"}, {62'b0, a_init_done, b_init_done}, 64'd3);
        check({name, "_ld_ready"}, {62'b0, a_ld_ready, b_fetch_ready}, 64'd3);
        check({name, "_ld_err_init"}, {63'b0, a_ld_err}, 64'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    endtask

    initial begin
        resetn       = 1'b0;
        a_fetch_req  = 1'b0; a_fetch_addr = '0; a_ld_we = 1'b0; a_ld_addr = '0; a_ld_data = '0;
        b_fetch_req  = 1'b0; b_fetch_addr = '0; b_ld_we = 1'b0; b_ld_addr = '0; b_ld_data = '0;

        vecs[0]  = '{1'b0, 64'h0,  32'h0, good(NOP), 1'b0};
        vecs[1]  = '{1'b0, 64'h3C, 32'h0, good(NOP), 1'b0};
        vecs[2]  = '{1'b0, 64'h8,  32'h0, good(NOP), 1'b0};
        vecs[3]  = '{1'b1, 64'h8,  32'hDEADBEEF, good(32'h0), 1'b0};
        vecs[4]  = '{1'b0, 64'h8,  32'h0, good(32'hDEADBEEF), 1'b0};
        vecs[5]  = '{1'b0, 64'h6,  32'h0, '{32'h0, 1'b1, 1'b0}, 1'b0};
        vecs[6]  = '{1'b0, 64'h40, 32'h0, '{32'h0, 1'b0, 1'b1}, 1'b0};
        vecs[7]  = '{1'b0, 64'h42, 32'h0, '{32'h0, 1'b1, 1'b1}, 1'b0};
        vecs[8]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, '{32'h0, 1'b0, 1'b1}, 1'b0};
        vecs[9]  = '{1'b1, 64'h40, 32'h12345678, good(32'h0), 1'b1};
        vecs[10] = '{1'b1, 64'h2,  32'h00000055, good(32'h0), 1'b1};
        vecs[11] = '{1'b1, 64'h0,  32'h00000011, good(32'h0), 1'b0};
        vecs[12] = '{1'b1, 64'h4,  32'h00000022, good(32'h0), 1'b0};
        vecs[13] = '{1'b1, 64'h8,  32'h00000033, good(32'h0), 1'b0};

        @(negedge clk);
        cycle();
        cycle();
        check("reset_outputs",
              {57'b0, a_fetch_valid, a_fetch_ready, a_ld_ready, a_ld_err, a_init_done,
               a_fault_misalign, a_fault_range}, 64'd0);
        check("reset_instr", {32'b0, a_fetch_instr}, 64'd0);
        resetn = 1'b1;
        wait_init("init1");

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_ld) load(vecs[i].addr, vecs[i].data, vecs[i].exp_ld_err);
            else               fetch(vecs[i].addr, vecs[i].exp);
        end

        // Back-to-back fetches, then an idle cycle where outputs must hold.
        for (int i = 0; i < 3; i++) begin
            a_fetch_req  = 1'b1;
            a_fetch_addr = 64'(4 * i);
            sb_q.push_back(good(model[i]));
            cycle();
            check("b2b_valid", {63'b0, a_fetch_valid}, 64'd1);
        end
        a_fetch_req = 1'b0;
        cycle();
        check("idle_no_valid", {63'b0, a_fetch_valid}, 64'd0);
        check("idle_hold", {32'b0, a_fetch_instr}, 64'h33);

        // Dropped out-of-range load must not have touched any word.
        for (int i = 0; i < DEPTH; i++) fetch(64'(4 * i), good(model[i]));

        // Same-cycle load and fetch to one word: read-before-write.
        a_ld_we      = 1'b1; a_ld_addr = 64'h4; a_ld_data = 32'hCAFEF00D;
        a_fetch_req  = 1'b1; a_fetch_addr = 64'h4;
        sb_q.push_back(good(model[1]));
        cycle();
        a_ld_we = 1'b0; a_fetch_req = 1'b0;
        model[1] = 32'hCAFEF00D;
        fetch(64'h4, good(32'hCAFEF00D));

        // Non-zero base: below-base wraps out of range, inside base is valid.
        b_fetch_req = 1'b1; b_fetch_addr = 64'hFFC;
        cycle();
        check("base_below", {29'b0, b_fetch_valid, b_fault_misalign, b_fault_range, b_fetch_instr},
              {29'b0, 1'b1, 1'b0, 1'b1, 32'h0});
        b_fetch_addr = 64'h103C;
        cycle();
        b_fetch_req = 1'b0;
        check("base_top", {29'b0, b_fetch_valid, b_fault_misalign, b_fault_range, b_fetch_instr},
              {29'b0, 1'b1, 1'b0, 1'b0, NOP});

        // Reset coinciding with a fetch discards it and restarts the sweep.
        a_fetch_req = 1'b1; a_fetch_addr = 64'h8;
        resetn = 1'b0;
        cycle();
        a_fetch_req = 1'b0;
        check("reset_discard_valid", {63'b0, a_fetch_valid}, 64'd0);
        resetn = 1'b1;
        wait_init("init2");
        fetch(64'h8, good(NOP));
        fetch(64'h4, good(NOP));

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
